// File: rtl/tile_pkg.sv
// Shared definitions for the tile renderer: default geometry, the fill FSM state type,
// the default palette and the tile address helper.
package tile_pkg;

  localparam int DEF_WIDTH       = 640;
  localparam int DEF_HEIGHT      = 480;
  localparam int DEF_TILE_W_LOG2 = 4;
  localparam int DEF_TILE_H_LOG2 = 4;
  localparam int DEF_COLOR_BITS  = 2;

  typedef enum logic {IDLE, FILL} fill_state_t;

  localparam logic [23:0] DEFAULT_PALETTE [4] = '{
    24'h000000, 24'h0000FF, 24'hFFFF00, 24'hFFFFFF
  };

  // Entries beyond the four predefined colours come up black.
  function automatic logic [23:0] default_color(input int idx);
    logic [1:0] sel;
    sel = idx[1:0];
    return (idx >= 0 && idx < 4) ? DEFAULT_PALETTE[sel] : 24'h000000;
  endfunction

  function automatic int tile_addr(input int col, input int row, input int cols);
    return row * cols + col;
  endfunction

endpackage

// File: rtl/tile_ram.sv
// Simple dual-port synchronous RAM: registered read port, write port, read-first on collision.
module tile_ram #(
  parameter int DEPTH = 1200,
  parameter int DW    = 2,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Separate read process so a same-address write returns the old word.
  always_ff @(posedge clk) begin
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/tile_renderer.sv
// Tile-map pixel source: looks up the tile under (x,y), maps it through a writable palette
// and registers r/g/b two edges later; supports single-tile writes and a whole-map fill.
module tile_renderer
  import tile_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int HEIGHT      = DEF_HEIGHT,
  parameter int TILE_W_LOG2 = DEF_TILE_W_LOG2,
  parameter int TILE_H_LOG2 = DEF_TILE_H_LOG2,
  parameter int COLOR_BITS  = DEF_COLOR_BITS,
  localparam int COLS  = WIDTH >> TILE_W_LOG2,
  localparam int ROWS  = HEIGHT >> TILE_H_LOG2,
  localparam int DEPTH = COLS * ROWS,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(COLS),
  localparam int RW    = $clog2(ROWS),
  localparam int NPAL  = 2 ** COLOR_BITS
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic [9:0]            x,
  input  logic [8:0]            y,
  output logic [7:0]            r,
  output logic [7:0]            g,
  output logic [7:0]            b,
  input  logic                  wr_en,
  input  logic [CW-1:0]         wr_col,
  input  logic [RW-1:0]         wr_row,
  input  logic [COLOR_BITS-1:0] wr_data,
  output logic                  wr_ready,
  input  logic                  fill_start,
  input  logic [COLOR_BITS-1:0] fill_data,
  output logic                  busy,
  output logic                  fill_done,
  input  logic                  pal_wr_en,
  input  logic [COLOR_BITS-1:0] pal_idx,
  input  logic [23:0]           pal_rgb
);

  fill_state_t           state;
  logic [AW-1:0]         fill_cnt;
  logic [COLOR_BITS-1:0] fill_val;
  logic                  fill_last;

  logic [AW-1:0]         rd_addr;
  logic [COLOR_BITS-1:0] rd_data;
  logic                  ram_we;
  logic [AW-1:0]         ram_wa;
  logic [COLOR_BITS-1:0] ram_wd;
  logic                  wr_in_range;

  logic                  oor_q;
  logic [23:0]           rgb_q;
  logic [23:0]           palette [NPAL];

  assign busy      = (state == FILL);
  assign wr_ready  = !busy;
  assign fill_last = busy && (int'(fill_cnt) == DEPTH - 1);

  assign rd_addr = AW'(tile_addr(int'(x >> TILE_W_LOG2), int'(y >> TILE_H_LOG2), COLS));
  assign wr_in_range = (int'(wr_col) < COLS) && (int'(wr_row) < ROWS);

  // The fill engine owns the write port while busy; single writes are simply dropped then.
  always_comb begin
    ram_we = 1'b0;
    ram_wa = '0;
    ram_wd = '0;
    if (busy) begin
      ram_we = 1'b1;
      ram_wa = fill_cnt;
      ram_wd = fill_val;
    end else if (wr_en && wr_in_range) begin
      ram_we = 1'b1;
      ram_wa = AW'(tile_addr(int'(wr_col), int'(wr_row), COLS));
      ram_wd = wr_data;
    end
  end

  tile_ram #(
    .DEPTH (DEPTH),
    .DW    (COLOR_BITS),
    .AW    (AW)
  ) u_ram (
    .clk     (CLOCK_50),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .wr_en   (ram_we),
    .wr_addr (ram_wa),
    .wr_data (ram_wd)
  );

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      fill_cnt  <= '0;
      fill_val  <= '0;
      fill_done <= 1'b0;
    end else begin
      fill_done <= fill_last;
      case (state)
        IDLE: begin
          if (fill_start) begin
            state    <= FILL;
            fill_cnt <= '0;
            fill_val <= fill_data;
          end
        end
        FILL: begin
          if (fill_last) state <= IDLE;
          else           fill_cnt <= fill_cnt + AW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NPAL; i++) palette[i] <= default_color(i);
    end else if (pal_wr_en) begin
      palette[pal_idx] <= pal_rgb;
    end
  end

  // Stage 1 runs alongside the RAM read; stage 2 resolves the palette colour.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      oor_q <= 1'b0;
      rgb_q <= '0;
    end else begin
      oor_q <= (int'(x) >= WIDTH) || (int'(y) >= HEIGHT);
      rgb_q <= oor_q ? 24'h000000 : palette[rd_data];
    end
  end

  assign r = rgb_q[23:16];
  assign g = rgb_q[15:8];
  assign b = rgb_q[7:0];

endmodule

// File: tb/tb_tile_renderer.sv
// Directed bench for tile_renderer: pixel vector tables per test phase plus hand-written
// sequences for fill timing, write arbitration, reset mid-fill and palette updates.
module tb_tile_renderer;

  logic        CLOCK_50 = 1'b0;
  logic        reset;
  logic [9:0]  x;
  logic [8:0]  y;
  logic [7:0]  r, g, b;
  logic        wr_en;
  logic [5:0]  wr_col;
  logic [4:0]  wr_row;
  logic [1:0]  wr_data;
  logic        wr_ready;
  logic        fill_start;
  logic [1:0]  fill_data;
  logic        busy;
  logic        fill_done;
  logic        pal_wr_en;
  logic [1:0]  pal_idx;
  logic [23:0] pal_rgb;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int          phase;
    logic [9:0]  px;
    logic [8:0]  py;
    logic [23:0] exp;
  } vec_t;

  vec_t vecs[$];

  tile_renderer dut (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .x          (x),
    .y          (y),
    .r          (r),
    .g          (g),
    .b          (b),
    .wr_en      (wr_en),
    .wr_col     (wr_col),
    .wr_row     (wr_row),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .fill_start (fill_start),
    .fill_data  (fill_data),
    .busy       (busy),
    .fill_done  (fill_done),
    .pal_wr_en  (pal_wr_en),
    .pal_idx    (pal_idx),
    .pal_rgb    (pal_rgb)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [9:0] px, input logic [8:0] py);
    x = px;
    y = py;
    step();
    step();
  endtask

  task automatic check_output(input string name, input logic [23:0] exp);
    check_val(name, {8'h00, r, g, b}, {8'h00, exp});
  endtask

  task automatic start_fill(input logic [1:0] d);
    fill_data  = d;
    fill_start = 1'b1;
    step();
    fill_start = 1'b0;
  endtask

  // Counts the cycles busy is seen high, bounded so a stuck fill still reaches the summary.
  task automatic wait_fill(output int cycles);
    cycles = 0;
    while (busy && cycles < 5000) begin
      cycles++;
      step();
    end
    if (busy) begin
      checks++;
      errors++;
      $display("[TB] FAIL fill_timeout: busy still 1 after %0d cycles, expected 0", cycles);
    end
  endtask

  task automatic run_phase(input int p);
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].phase == p) begin
        apply_stimulus(vecs[i].px, vecs[i].py);
        check_output($sformatf("pix_p%0d(%0d,%0d)", p, vecs[i].px, vecs[i].py), vecs[i].exp);
      end
    end
  endtask

  initial begin
    int cyc;

    // Phase 0: whole map index 1 (blue); out-of-range pixels stay black.
    vecs.push_back('{0, 10'd0,    9'd0,   24'h0000FF});
    vecs.push_back('{0, 10'd639,  9'd479, 24'h0000FF});
    vecs.push_back('{0, 10'd320,  9'd240, 24'h0000FF});
    vecs.push_back('{0, 10'd15,   9'd16,  24'h0000FF});
    vecs.push_back('{0, 10'd640,  9'd10,  24'h000000});
    vecs.push_back('{0, 10'd10,   9'd480, 24'h000000});
    vecs.push_back('{0, 10'd1023, 9'd511, 24'h000000});
    // Phase 1: map index 0, tile (5,3) = 2 (yellow).
    vecs.push_back('{1, 10'd80,   9'd48,  24'hFFFF00});
    vecs.push_back('{1, 10'd95,   9'd63,  24'hFFFF00});
    vecs.push_back('{1, 10'd88,   9'd55,  24'hFFFF00});
    vecs.push_back('{1, 10'd79,   9'd48,  24'h000000});
    vecs.push_back('{1, 10'd96,   9'd63,  24'h000000});
    vecs.push_back('{1, 10'd80,   9'd47,  24'h000000});
    vecs.push_back('{1, 10'd80,   9'd64,  24'h000000});
    vecs.push_back('{1, 10'd80,   9'd16,  24'h000000});
    // Phase 2: tiles 0..599 blue, 600..1199 yellow after the interrupted fill.
    vecs.push_back('{2, 10'd0,    9'd0,   24'h0000FF});
    vecs.push_back('{2, 10'd624,  9'd224, 24'h0000FF});
    vecs.push_back('{2, 10'd639,  9'd239, 24'h0000FF});
    vecs.push_back('{2, 10'd0,    9'd240, 24'hFFFF00});
    vecs.push_back('{2, 10'd639,  9'd479, 24'hFFFF00});

    reset      = 1'b1;
    x          = '0;
    y          = '0;
    wr_en      = 1'b0;
    wr_col     = '0;
    wr_row     = '0;
    wr_data    = '0;
    fill_start = 1'b0;
    fill_data  = '0;
    pal_wr_en  = 1'b0;
    pal_idx    = '0;
    pal_rgb    = '0;

    #5;
    check_output("reset_rgb", 24'h000000);
    check_val("reset_busy", 32'(busy), 32'd0);
    check_val("reset_fill_done", 32'(fill_done), 32'd0);
    check_val("reset_wr_ready", 32'(wr_ready), 32'd1);
    step();
    step();
    reset = 1'b0;
    step();

    start_fill(2'd1);
    check_val("fill1_busy_rise", 32'(busy), 32'd1);
    wait_fill(cyc);
    check_val("fill1_busy_cycles", 32'(cyc), 32'd1200);
    check_val("fill1_done_pulse", 32'(fill_done), 32'd1);
    step();
    check_val("fill1_done_clear", 32'(fill_done), 32'd0);

    run_phase(0);

    start_fill(2'd0);
    wait_fill(cyc);
    step();
    wr_en   = 1'b1;
    wr_col  = 6'd5;
    wr_row  = 5'd3;
    wr_data = 2'd2;
    #1;
    check_val("wr_ready_idle", 32'(wr_ready), 32'd1);
    step();
    // Column 45 is off the map: accepted but must not land on tile (5,1).
    wr_col  = 6'd45;
    wr_row  = 5'd0;
    wr_data = 2'd3;
    #1;
    check_val("wr_ready_oor", 32'(wr_ready), 32'd1);
    step();
    wr_en = 1'b0;

    run_phase(1);

    start_fill(2'd3);
    repeat (10) step();
    wr_en   = 1'b1;
    wr_col  = 6'd0;
    wr_row  = 5'd0;
    wr_data = 2'd2;
    #1;
    check_val("wr_ready_busy", 32'(wr_ready), 32'd0);
    step();
    wr_en = 1'b0;
    wait_fill(cyc);
    apply_stimulus(10'd0, 9'd0);
    check_output("busy_write_dropped", 24'hFFFFFF);

    wr_en      = 1'b1;
    wr_col     = 6'd1;
    wr_row     = 5'd0;
    wr_data    = 2'd2;
    fill_data  = 2'd0;
    fill_start = 1'b1;
    #1;
    check_val("same_cycle_wr_ready", 32'(wr_ready), 32'd1);
    step();
    wr_en      = 1'b0;
    fill_start = 1'b0;
    check_val("same_cycle_busy", 32'(busy), 32'd1);
    wait_fill(cyc);
    check_val("same_cycle_busy_cycles", 32'(cyc), 32'd1200);
    apply_stimulus(10'd16, 9'd0);
    check_output("same_cycle_overwritten", 24'h000000);

    start_fill(2'd2);
    wait_fill(cyc);
    step();
    start_fill(2'd1);
    repeat (600) step();
    reset = 1'b1;
    #1;
    check_val("midfill_reset_busy", 32'(busy), 32'd0);
    check_val("midfill_reset_done", 32'(fill_done), 32'd0);
    check_output("midfill_reset_rgb", 24'h000000);
    step();
    step();
    check_val("midfill_reset_done_held", 32'(fill_done), 32'd0);
    reset = 1'b0;
    step();
    check_val("midfill_after_busy", 32'(busy), 32'd0);
    check_val("midfill_after_done", 32'(fill_done), 32'd0);

    run_phase(2);

    apply_stimulus(10'd0, 9'd0);
    check_output("pal_before", 24'h0000FF);
    pal_idx   = 2'd1;
    pal_rgb   = 24'h123456;
    pal_wr_en = 1'b1;
    step();
    pal_wr_en = 1'b0;
    check_output("pal_write_edge", 24'h0000FF);
    step();
    check_output("pal_next_edge", 24'h123456);
    apply_stimulus(10'd0, 9'd240);
    check_output("pal_other_entry", 24'hFFFF00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
